// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and flag bundle type
//
// Purpose: shared timing defaults, the per-pixel flag bundle carried through
//          the alignment delay line, and a helper for the total line/frame count.
// Ports:   none (package).

package vga_timing_pkg;

   localparam int DEF_VIDEO_WIDTH = 3;
   localparam int DEF_ACTIVE_COLS = 640;
   localparam int DEF_H_FRONT     = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BACK      = 48;
   localparam int DEF_ACTIVE_ROWS = 480;
   localparam int DEF_V_FRONT     = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BACK      = 33;
   localparam bit DEF_HSYNC_POL   = 1'b0;
   localparam bit DEF_VSYNC_POL   = 1'b0;
   localparam int DEF_VIDEO_DELAY = 2;
   localparam int DEF_COUNT_WIDTH = 10;

   // Flags are stored as "asserted" bits so a cleared pipeline means idle,
   // independent of the configured sync polarity.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
      logic frame_start;
   } vga_flags_t;

   function automatic int total_count(input int active, input int front,
                                      input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-gated shift register of parametrised width and depth
//
// Purpose: delays a WIDTH-bit word by DEPTH enabled ticks; DEPTH=0 is a wire.
// Ports:   clk   - clock
//          rst_n - asynchronous active-low reset, clears every stage
//          en    - shift enable; stages hold when low
//          d     - word entering the line
//          q     - word leaving the line

module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst_n, en};
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] stages [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
            end else if (en) begin
               stages[0] <= d;
               for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
         end

         assign q = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_porch.sv
// rtl/vga_timing_porch.sv - parametrised VGA timing generator and video aligner
//
// Purpose: owns the column/row counters, decodes sync/active/frame-start per
//          count, delays those flags to meet the pixel generator's latency and
//          registers them together with blanked video towards the VGA pins.
// Ports:   i_Clk, i_Rst_L           - clock, asynchronous active-low reset
//          i_Pix_En                 - pixel-tick enable; everything holds when low
//          i_Red/Grn/Blu_Video      - video from the pixel generator
//          o_Col_Count, o_Row_Count - current counters, to the pixel generator
//          o_HSync, o_VSync         - sync outputs at configured polarity
//          o_Active                 - data enable
//          o_Frame_Start            - one-tick pulse on output pixel (0,0)
//          o_Red/Grn/Blu_Video      - aligned, blanked video

module vga_timing_porch
   import vga_timing_pkg::*;
#(
   parameter int VIDEO_WIDTH = DEF_VIDEO_WIDTH,
   parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
   parameter int H_FRONT     = DEF_H_FRONT,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BACK      = DEF_H_BACK,
   parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
   parameter int V_FRONT     = DEF_V_FRONT,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BACK      = DEF_V_BACK,
   parameter bit HSYNC_POL   = DEF_HSYNC_POL,
   parameter bit VSYNC_POL   = DEF_VSYNC_POL,
   parameter int VIDEO_DELAY = DEF_VIDEO_DELAY,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_Pix_En,
   input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
   output logic [COUNT_WIDTH-1:0] o_Col_Count,
   output logic [COUNT_WIDTH-1:0] o_Row_Count,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic                   o_Active,
   output logic                   o_Frame_Start,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam int TOTAL_COLS   = total_count(ACTIVE_COLS, H_FRONT, H_SYNC, H_BACK);
   localparam int TOTAL_ROWS   = total_count(ACTIVE_ROWS, V_FRONT, V_SYNC, V_BACK);
   localparam int H_SYNC_START = ACTIVE_COLS + H_FRONT;
   localparam int V_SYNC_START = ACTIVE_ROWS + V_FRONT;

   localparam logic [COUNT_WIDTH-1:0] COL_LAST    = COUNT_WIDTH'(TOTAL_COLS - 1);
   localparam logic [COUNT_WIDTH-1:0] ROW_LAST    = COUNT_WIDTH'(TOTAL_ROWS - 1);
   localparam logic [COUNT_WIDTH-1:0] COL_ACT_END = COUNT_WIDTH'(ACTIVE_COLS);
   localparam logic [COUNT_WIDTH-1:0] ROW_ACT_END = COUNT_WIDTH'(ACTIVE_ROWS);
   localparam logic [COUNT_WIDTH-1:0] HS_FIRST    = COUNT_WIDTH'(H_SYNC_START);
   localparam logic [COUNT_WIDTH-1:0] HS_LAST     = COUNT_WIDTH'(H_SYNC_START + H_SYNC - 1);
   localparam logic [COUNT_WIDTH-1:0] VS_FIRST    = COUNT_WIDTH'(V_SYNC_START);
   localparam logic [COUNT_WIDTH-1:0] VS_LAST     = COUNT_WIDTH'(V_SYNC_START + V_SYNC - 1);
   localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

   logic [COUNT_WIDTH-1:0] col;
   logic [COUNT_WIDTH-1:0] row;
   vga_flags_t             flags_now;
   vga_flags_t             flags_aligned;

   assign o_Col_Count = col;
   assign o_Row_Count = row;

   // Column and row wrap together on the last pixel of the frame.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         col <= '0;
         row <= '0;
      end else if (i_Pix_En) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end

   always_comb begin
      flags_now             = '0;
      flags_now.hsync       = (col >= HS_FIRST) && (col <= HS_LAST);
      flags_now.vsync       = (row >= VS_FIRST) && (row <= VS_LAST);
      flags_now.active      = (col < COL_ACT_END) && (row < ROW_ACT_END);
      flags_now.frame_start = (col == '0) && (row == '0);
   end

   // VIDEO_DELAY stages here plus the output register below give the full
   // VIDEO_DELAY+1 alignment; the middle tap lines up with incoming video.
   vga_delay_line #(
      .WIDTH ($bits(vga_flags_t)),
      .DEPTH (VIDEO_DELAY)
   ) u_flag_delay (
      .clk   (i_Clk),
      .rst_n (i_Rst_L),
      .en    (i_Pix_En),
      .d     (flags_now),
      .q     (flags_aligned)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_HSync       <= ~HSYNC_POL;
         o_VSync       <= ~VSYNC_POL;
         o_Active      <= 1'b0;
         o_Frame_Start <= 1'b0;
         o_Red_Video   <= '0;
         o_Grn_Video   <= '0;
         o_Blu_Video   <= '0;
      end else if (i_Pix_En) begin
         o_HSync       <= flags_aligned.hsync ? HSYNC_POL : ~HSYNC_POL;
         o_VSync       <= flags_aligned.vsync ? VSYNC_POL : ~VSYNC_POL;
         o_Active      <= flags_aligned.active;
         o_Frame_Start <= flags_aligned.frame_start;
         o_Red_Video   <= flags_aligned.active ? i_Red_Video : '0;
         o_Grn_Video   <= flags_aligned.active ? i_Grn_Video : '0;
         o_Blu_Video   <= flags_aligned.active ? i_Blu_Video : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_porch.sv
// tb/tb_vga_timing_porch.sv - self-checking bench for vga_timing_porch
//
// Purpose: drives a default-timing instance and a small positive-polarity,
//          zero-latency instance with a latency-matched pixel generator and
//          compares every output against a position-based reference model.
// Ports:   none (top-level bench).

module tb_vga_timing_porch;

   typedef struct {
      int ac, hf, hs, hb, ar, vf, vs, vb, hp, vp, d;
   } tim_t;

   typedef struct {
      int col, row, hs, vs, act, fs, vid;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic pix_en;

   logic [2:0] ra, ga, ba, rb, gb, bb;
   logic [9:0] col_a, row_a;
   logic [3:0] col_b, row_b;
   logic       hs_a, vs_a, act_a, fs_a, hs_b, vs_b, act_b, fs_b;
   logic [2:0] ro_a, go_a, bo_a, ro_b, go_b, bo_b;

   tim_t ta, tb;
   int   m;
   int   tests;
   int   failed;

   always #5 clk = ~clk;

   vga_timing_porch u_dut_a (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en),
      .i_Red_Video(ra), .i_Grn_Video(ga), .i_Blu_Video(ba),
      .o_Col_Count(col_a), .o_Row_Count(row_a),
      .o_HSync(hs_a), .o_VSync(vs_a), .o_Active(act_a), .o_Frame_Start(fs_a),
      .o_Red_Video(ro_a), .o_Grn_Video(go_a), .o_Blu_Video(bo_a)
   );

   vga_timing_porch #(
      .VIDEO_WIDTH(3), .ACTIVE_COLS(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .ACTIVE_ROWS(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .VIDEO_DELAY(0), .COUNT_WIDTH(4)
   ) u_dut_b (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en),
      .i_Red_Video(rb), .i_Grn_Video(gb), .i_Blu_Video(bb),
      .o_Col_Count(col_b), .o_Row_Count(row_b),
      .o_HSync(hs_b), .o_VSync(vs_b), .o_Active(act_b), .o_Frame_Start(fs_b),
      .o_Red_Video(ro_b), .o_Grn_Video(go_b), .o_Blu_Video(bo_b)
   );

   // Pixel content for frame position p, packed {red, green, blue}.
   function automatic int pix(int p);
      return (p * 5 + (p / 7) * 3 + 1) % 512;
   endfunction

   function automatic int frame_len(tim_t t);
      return (t.ac + t.hf + t.hs + t.hb) * (t.ar + t.vf + t.vs + t.vb);
   endfunction

   // Expected outputs after m enabled ticks since reset.
   function automatic exp_t model(tim_t t, int mm);
      exp_t e;
      int   tc, tr, p, c, r;
      tc = t.ac + t.hf + t.hs + t.hb;
      tr = t.ar + t.vf + t.vs + t.vb;
      e.col = mm % tc;
      e.row = (mm / tc) % tr;
      e.hs  = 1 - t.hp;
      e.vs  = 1 - t.vp;
      e.act = 0;
      e.fs  = 0;
      e.vid = 0;
      if (mm >= t.d + 1) begin
         p = (mm - t.d - 1) % frame_len(t);
         c = p % tc;
         r = p / tc;
         if (c >= t.ac + t.hf && c < t.ac + t.hf + t.hs) e.hs = t.hp;
         if (r >= t.ar + t.vf && r < t.ar + t.vf + t.vs) e.vs = t.vp;
         e.act = (c < t.ac && r < t.ar) ? 1 : 0;
         e.fs  = (p == 0) ? 1 : 0;
         if (e.act != 0) e.vid = pix(p);
      end
      return e;
   endfunction

   // Pixel generator with latency t.d: the capture at tick mm must carry
   // the pixel for position mm - t.d.
   function automatic int gen_val(tim_t t, int mm);
      if (mm >= t.d) return pix((mm - t.d) % frame_len(t));
      return int'($urandom_range(0, 511));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, m);
      end
   endtask

   task automatic check_all();
      exp_t ea, eb;
      ea = model(ta, m);
      eb = model(tb, m);
      chk("a_col",   32'(col_a), 32'(ea.col));
      chk("a_row",   32'(row_a), 32'(ea.row));
      chk("a_hsync", 32'(hs_a),  32'(ea.hs));
      chk("a_vsync", 32'(vs_a),  32'(ea.vs));
      chk("a_act",   32'(act_a), 32'(ea.act));
      chk("a_fs",    32'(fs_a),  32'(ea.fs));
      chk("a_video", 32'({ro_a, go_a, bo_a}), 32'(ea.vid));
      chk("b_col",   32'(col_b), 32'(eb.col));
      chk("b_row",   32'(row_b), 32'(eb.row));
      chk("b_hsync", 32'(hs_b),  32'(eb.hs));
      chk("b_vsync", 32'(vs_b),  32'(eb.vs));
      chk("b_act",   32'(act_b), 32'(eb.act));
      chk("b_fs",    32'(fs_b),  32'(eb.fs));
      chk("b_video", 32'({ro_b, go_b, bo_b}), 32'(eb.vid));
   endtask

   // Called at a falling edge: check, drive the next tick, advance one cycle.
   task automatic step(bit en);
      check_all();
      pix_en = en;
      if (en && rst_n) begin
         {ra, ga, ba} = 9'(gen_val(ta, m));
         {rb, gb, bb} = 9'(gen_val(tb, m));
      end else begin
         {ra, ga, ba} = 9'($urandom_range(0, 511));
         {rb, gb, bb} = 9'($urandom_range(0, 511));
      end
      @(posedge clk);
      if (rst_n && en) m++;
      @(negedge clk);
   endtask

   initial begin
      ta     = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
      tb     = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 1, 0};
      tests  = 0;
      failed = 0;
      m      = 0;
      rst_n  = 1'b0;
      pix_en = 1'b0;
      {ra, ga, ba, rb, gb, bb} = '0;

      @(negedge clk);
      repeat (2) step(1'b1);
      rst_n = 1'b1;

      // Free run: small instance wraps many frames, default reaches line 2.
      repeat (2000) step(1'b1);

      // Asynchronous reset away from any clock edge.
      #2 rst_n = 1'b0;
      m = 0;
      #1 check_all();
      @(negedge clk);
      repeat (2) step(1'b1);
      rst_n = 1'b1;

      repeat (2500) step(1'b1);

      // Random stalls: outputs must hold while enable is low.
      repeat (3000) step($urandom_range(0, 3) != 0);

      repeat (200) step(1'b1);
      check_all();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
